// File: rtl/tt_scan_ctrl.sv
// Truth-table scan controller: sweeps every input vector of a small function unit and
// captures its output into a table. Optional error log: `TT_SCAN_ERRLOG_EN.
// `expect` and `table` are SystemVerilog keywords, so those ports are exp_mask and tbl.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | driving idx, counting settle cycles, sampling fn_out
// DONE  | table complete, result held until next start
module tt_scan_ctrl #(
  parameter int IW     = 3,
  parameter int SETTLE = 0
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [2**IW-1:0] exp_mask,
  output logic [IW-1:0]   fn_in,
  input  logic            fn_out,
  output logic            busy,
  output logic            done,
  output logic [2**IW-1:0] tbl,
  output logic            pass
`ifdef TT_SCAN_ERRLOG_EN
  ,
  output logic [IW-1:0]   first_bad,
  output logic [IW:0]     bad_cnt
`endif
);

  localparam int TW = 2**IW;
  localparam logic [IW-1:0] LAST   = IW'(TW - 1);
  localparam logic [3:0]    CNT_LD = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state;
  logic [IW-1:0]   idx;
  logic [3:0]      cnt;
  logic [TW-1:0]   expect_q;

`ifdef TT_SCAN_ERRLOG_EN
  localparam logic [IW:0] ONE = (IW+1)'(1);
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      idx      <= '0;
      cnt      <= '0;
      expect_q <= '0;
      tbl      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef TT_SCAN_ERRLOG_EN
      first_bad <= '0;
      bad_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= SCAN;
            idx      <= '0;
            cnt      <= CNT_LD;
            tbl      <= '0;
            expect_q <= exp_mask;
            busy     <= 1'b1;
            done     <= 1'b0;
`ifdef TT_SCAN_ERRLOG_EN
            first_bad <= '0;
            bad_cnt   <= '0;
`endif
          end
        end
        SCAN: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            tbl[idx] <= fn_out;
`ifdef TT_SCAN_ERRLOG_EN
            if (fn_out != expect_q[idx]) begin
              if (bad_cnt == '0) first_bad <= idx;
              bad_cnt <= bad_cnt + ONE;
            end
`endif
            // idx stays at the last vector so fn_in holds TW-1 in DONE
            if (idx == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
              cnt <= CNT_LD;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign fn_in = idx;
  assign pass  = done & (tbl == expect_q);

endmodule

// File: tb/tb_tt_scan_ctrl.sv
// Directed bench for tt_scan_ctrl: one instance with SETTLE=0, one with SETTLE=2,
// each fed by a behavioural 3-input function selected by the bench.
module tb_tt_scan_ctrl;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic [7:0] mask0 = 8'h00, mask2 = 8'h00;
  logic       fsel0 = 1'b0, fsel2 = 1'b1;
  logic [2:0] fn_in0, fn_in2;
  logic       fn_out0, fn_out2;
  logic       busy0, busy2, done0, done2, pass0, pass2;
  logic [7:0] tbl0, tbl2;
`ifdef TT_SCAN_ERRLOG_EN
  logic [2:0] fb0, fb2;
  logic [3:0] bc0, bc2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // sel 0: ~X2 & (X1 | X0) -> 8'h0E ; sel 1: majority -> 8'hE8
  function automatic logic fn(input logic sel, input logic [2:0] x);
    if (!sel) return ~x[2] & (x[1] | x[0]);
    return (x[2] & x[1]) | (x[2] & x[0]) | (x[1] & x[0]);
  endfunction

  assign fn_out0 = fn(fsel0, fn_in0);
  assign fn_out2 = fn(fsel2, fn_in2);

  tt_scan_ctrl #(.IW(3), .SETTLE(0)) u0 (
    .clk(clk), .clr(clr), .start(start), .exp_mask(mask0), .fn_in(fn_in0),
    .fn_out(fn_out0), .busy(busy0), .done(done0), .tbl(tbl0), .pass(pass0)
`ifdef TT_SCAN_ERRLOG_EN
    , .first_bad(fb0), .bad_cnt(bc0)
`endif
  );

  tt_scan_ctrl #(.IW(3), .SETTLE(2)) u2 (
    .clk(clk), .clr(clr), .start(start), .exp_mask(mask2), .fn_in(fn_in2),
    .fn_out(fn_out2), .busy(busy2), .done(done2), .tbl(tbl2), .pass(pass2)
`ifdef TT_SCAN_ERRLOG_EN
    , .first_bad(fb2), .bad_cnt(bc2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // cycles after the accepting edge until u0 reports done; 40 means it never did
  task automatic wait_done0(output int n);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (done0) break;
    end
  endtask

  initial begin
    int n, d0, d2, hold_err;

    #12;
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_tbl",  tbl0, 0);
    chk("rst_fn_in", fn_in0, 0);
    clr = 1'b1;
    tick();

    // scan 1: u0 function A / 8'h0E, u2 majority / 8'hE8
    fsel0 = 1'b0; mask0 = 8'h0E;
    fsel2 = 1'b1; mask2 = 8'hE8;
    pulse_start();
    chk("s1_busy_after_e0", busy0, 1);
    d0 = 0; d2 = 0; hold_err = 0;
    if (fn_in2 !== 3'd0) hold_err++;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (done0 && d0 == 0) d0 = k;
      if (done2 && d2 == 0) d2 = k;
      if (k < 24 && fn_in2 !== 3'(k / 3)) hold_err++;
    end
    chk("s1_done_cyc0", d0, 8);
    chk("s1_done_cyc2", d2, 24);
    chk("s2_fn_in_hold", hold_err, 0);
    chk("s1_tbl0", tbl0, 8'h0E);
    chk("s1_pass0", pass0, 1);
    chk("s1_done_held", done0, 1);
    chk("s1_fn_in_last", fn_in0, 7);
    chk("s1_tbl2", tbl2, 8'hE8);
    chk("s1_pass2", pass2, 1);
    chk("s1_busy2_low", busy2, 0);

    // scan 2: back-to-back restart from DONE with a mismatching mask
    mask0 = 8'h0F;
    pulse_start();
    chk("s2_done_drop", done0, 0);
    chk("s2_pass_drop", pass0, 0);
    chk("s2_tbl_clear", tbl0, 0);
    chk("s2_busy", busy0, 1);
    wait_done0(n);
    chk("s2_done_cyc", n, 8);
    chk("s2_tbl", tbl0, 8'h0E);
    chk("s2_pass", pass0, 0);
`ifdef TT_SCAN_ERRLOG_EN
    chk("s2_first_bad", fb0, 0);
    chk("s2_bad_cnt", bc0, 1);
`endif
    repeat (20) tick();

    // scan 3: start pulsed again mid-scan is ignored
    mask0 = 8'h0E;
    pulse_start();
    repeat (3) tick();
    pulse_start();
    n = 4;
    while (n < 40 && !done0) begin
      tick();
      n++;
    end
    chk("s3_done_cyc", n, 8);
    chk("s3_tbl", tbl0, 8'h0E);
    chk("s3_pass", pass0, 1);
`ifdef TT_SCAN_ERRLOG_EN
    chk("s3_bad_cnt", bc0, 0);
`endif
    repeat (20) tick();

    // scan 4: asynchronous abort while idx=4, then a full clean scan
    pulse_start();
    repeat (4) tick();
    chk("s4_idx4", fn_in0, 4);
    #2 clr = 1'b0;
    #1;
    chk("s4_abort_busy", busy0, 0);
    chk("s4_abort_tbl", tbl0, 0);
    chk("s4_abort_fn_in", fn_in0, 0);
    chk("s4_abort_done", done0, 0);
    #1 clr = 1'b1;
    tick();
    pulse_start();
    wait_done0(n);
    chk("s4_done_cyc", n, 8);
    chk("s4_tbl", tbl0, 8'h0E);
    chk("s4_pass", pass0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
